// File: rtl/mem_access_stage_if.sv
// Data-memory bus: single-outstanding req/ack; request-side signals are driven
// by the master and held stable until the slave returns ack with read data.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: loads/stores over a req/ack bus, 3-cycle minimum (+1 per ack-wait cycle).
// Stalls the upstream pipe while an access is in flight; non-memory ops pass through untouched.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        regwrite_mem,
    input  logic        memtoreg_mem_in,
    input  logic        memread_mem,
    input  logic        memwrite_mem,
    input  logic [2:0]  funct3_mem,
    mem_access_stage_if.master dmem,
    output logic [31:0] alu_result_mem1,
    output logic [4:0]  rd_mem_out1,
    output logic        memtoreg_mem,
    output logic        regwrite_mem_out1,
    output logic [31:0] mem_data_mem1,
    output logic        stall_mem,
    output logic        mem_fault,
    output logic        fault_is_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tflag_q, tflag_d;

    logic        access, illegal, misaligned, bad_access, start;
    logic        expire, in_idle, in_req, in_done;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign access  = memread_mem | memwrite_mem;
    assign illegal = (memread_mem & memwrite_mem)
                   | (memread_mem & ((funct3_mem == 3'd3) | (funct3_mem == 3'd6) | (funct3_mem == 3'd7)))
                   | (memwrite_mem & (funct3_mem > 3'd2));
    // funct3[1:0] encodes access size for both loads and stores
    assign misaligned = ((funct3_mem[1:0] == 2'b01) & alu_result_mem[0])
                      | ((funct3_mem[1:0] == 2'b10) & (alu_result_mem[1:0] != 2'b00));
    assign bad_access = illegal | misaligned;

    assign in_idle = (state_q == S_IDLE);
    assign in_req  = (state_q == S_REQ);
    assign in_done = (state_q == S_DONE);
    assign start   = in_idle & access & ~bad_access;
    assign expire  = (TMO != 32'd0) && ((cnt_q + 32'd1) >= TMO);

    always_comb begin
        st_wdata = rs2_data_mem;
        st_be    = 4'b0000;
        if (memwrite_mem) begin
            case (funct3_mem[1:0])
                2'b00: begin
                    st_wdata = {4{rs2_data_mem[7:0]}};
                    st_be    = 4'b0001 << alu_result_mem[1:0];
                end
                2'b01: begin
                    st_wdata = {2{rs2_data_mem[15:0]}};
                    st_be    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = rs2_data_mem;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = dmem.dmem_rdata[7:0];
            2'd1:    ld_byte = dmem.dmem_rdata[15:8];
            2'd2:    ld_byte = dmem.dmem_rdata[23:16];
            default: ld_byte = dmem.dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        addr_lo_d = addr_lo_q;
        funct3_d  = funct3_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        tflag_d   = tflag_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    we_d      = memwrite_mem;
                    addr_d    = {alu_result_mem[31:2], 2'b00};
                    wdata_d   = st_wdata;
                    be_d      = st_be;
                    addr_lo_d = alu_result_mem[1:0];
                    funct3_d  = funct3_mem;
                    cnt_d     = 32'd0;
                end
            end
            S_REQ: begin
                // ack in the expiry cycle takes priority over the timeout
                if (dmem.dmem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : ld_fmt;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (expire) begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        tflag_d = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                tflag_d = 1'b0;
                cnt_d   = 32'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            addr_lo_q <= 2'd0;
            funct3_q  <= 3'd0;
            rdata_q   <= 32'd0;
            cnt_q     <= 32'd0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            addr_lo_q <= addr_lo_d;
            funct3_q  <= funct3_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            tflag_q   <= tflag_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign alu_result_mem1   = alu_result_mem;
    assign rd_mem_out1       = rd_mem;
    assign memtoreg_mem      = memtoreg_mem_in;
    // rst gating keeps the stall/fault lines quiet even while an access is presented in reset
    assign stall_mem         = ~rst & (start | in_req);
    assign mem_fault         = ~rst & ((in_idle & access & bad_access) | (in_done & tflag_q));
    assign fault_is_timeout  = ~rst & in_done & tflag_q;
    assign mem_data_mem1     = (~rst & in_done) ? rdata_q : 32'd0;
    assign regwrite_mem_out1 = regwrite_mem & ~stall_mem & ~mem_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed test-plan steps then random ops against a reference model.
module tb_mem_access_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_mem, rs2_data_mem;
    logic [4:0]  rd_mem;
    logic        regwrite_mem, memtoreg_mem_in, memread_mem, memwrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_result_mem1, mem_data_mem1;
    logic [4:0]  rd_mem_out1;
    logic        memtoreg_mem, regwrite_mem_out1, stall_mem, mem_fault, fault_is_timeout;

    int total = 0;
    int bad   = 0;

    mem_access_stage_if dmem_if ();

    mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_result_mem   (alu_result_mem),
        .rs2_data_mem     (rs2_data_mem),
        .rd_mem           (rd_mem),
        .regwrite_mem     (regwrite_mem),
        .memtoreg_mem_in  (memtoreg_mem_in),
        .memread_mem      (memread_mem),
        .memwrite_mem     (memwrite_mem),
        .funct3_mem       (funct3_mem),
        .dmem             (dmem_if),
        .alu_result_mem1  (alu_result_mem1),
        .rd_mem_out1      (rd_mem_out1),
        .memtoreg_mem     (memtoreg_mem),
        .regwrite_mem_out1(regwrite_mem_out1),
        .mem_data_mem1    (mem_data_mem1),
        .stall_mem        (stall_mem),
        .mem_fault        (mem_fault),
        .fault_is_timeout (fault_is_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules, written as plain arithmetic on access size
    function automatic bit ref_bad(input bit rd, input bit wr, input int f3, input logic [31:0] addr);
        int nbytes;
        if (rd && wr) return 1'b1;
        if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
        if (wr && f3 > 2) return 1'b1;
        nbytes = 1 << (f3 % 4);
        return (int'(addr % 4) % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> ((addr % 4) * 8)) & 32'hFF;
        h = (w >> ((addr & 32'd2) * 8)) & 32'hFFFF;
        case (f3)
            0: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            4: return b;
            1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_be(input int f3, input logic [31:0] addr);
        if (f3 == 0) return 32'd1 << (addr % 4);
        if (f3 == 1) return 32'd3 << (addr & 32'd2);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] rs2);
        if (f3 == 0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    // Runs one instruction from posedge+1; delay = REQ cycles without ack before ack (>=TMO: none)
    task automatic do_op(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdw,
                         input int delay, input bit regw, input logic [4:0] rdi);
        bit got;
        bit tout;
        int k;
        memread_mem     = rd;
        memwrite_mem    = wr;
        funct3_mem      = f3;
        alu_result_mem  = addr;
        rs2_data_mem    = rs2;
        rd_mem          = rdi;
        regwrite_mem    = regw;
        memtoreg_mem_in = rd;
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'd0;
        if (!(rd || wr)) begin
            dmem_if.dmem_ack = 1'b1;
            #4;
            chk({nm, ":alu_pass"}, alu_result_mem1, addr);
            chk({nm, ":rd_pass"}, 32'(rd_mem_out1), 32'(rdi));
            chk({nm, ":stall"}, 32'(stall_mem), 32'd0);
            chk({nm, ":regwrite"}, 32'(regwrite_mem_out1), 32'(regw));
            chk({nm, ":fault"}, 32'(mem_fault), 32'd0);
            step();
            chk({nm, ":ack_ignored_req"}, 32'(dmem_if.dmem_req), 32'd0);
            dmem_if.dmem_ack = 1'b0;
            return;
        end
        #4;
        chk({nm, ":memtoreg"}, 32'(memtoreg_mem), 32'(rd));
        if (ref_bad(rd, wr, int'(f3), addr)) begin
            chk({nm, ":bad_fault"}, 32'(mem_fault), 32'd1);
            chk({nm, ":bad_is_tmo"}, 32'(fault_is_timeout), 32'd0);
            chk({nm, ":bad_stall"}, 32'(stall_mem), 32'd0);
            chk({nm, ":bad_regwrite"}, 32'(regwrite_mem_out1), 32'd0);
            step();
            chk({nm, ":bad_no_req"}, 32'(dmem_if.dmem_req), 32'd0);
            memread_mem  = 1'b0;
            memwrite_mem = 1'b0;
            return;
        end
        chk({nm, ":c0_stall"}, 32'(stall_mem), 32'd1);
        chk({nm, ":c0_req"}, 32'(dmem_if.dmem_req), 32'd0);
        chk({nm, ":c0_regwrite"}, 32'(regwrite_mem_out1), 32'd0);
        got  = 1'b0;
        tout = 1'b0;
        k    = 0;
        while (!got && !tout) begin
            step();
            dmem_if.dmem_ack   = (k == delay);
            dmem_if.dmem_rdata = (k == delay) ? rdw : $urandom;
            #4;
            chk({nm, ":req"}, 32'(dmem_if.dmem_req), 32'd1);
            chk({nm, ":addr"}, dmem_if.dmem_addr, addr & 32'hFFFF_FFFC);
            chk({nm, ":we"}, 32'(dmem_if.dmem_we), 32'(wr));
            chk({nm, ":be"}, 32'(dmem_if.dmem_be), wr ? ref_be(int'(f3), addr) : 32'd0);
            if (wr) chk({nm, ":wdata"}, dmem_if.dmem_wdata, ref_wdata(int'(f3), rs2));
            chk({nm, ":req_stall"}, 32'(stall_mem), 32'd1);
            chk({nm, ":req_regwrite"}, 32'(regwrite_mem_out1), 32'd0);
            if (k == delay) got = 1'b1;
            else if (k == TMO - 1) tout = 1'b1;
            k++;
        end
        step();
        dmem_if.dmem_ack = 1'b0;
        #4;
        chk({nm, ":done_req"}, 32'(dmem_if.dmem_req), 32'd0);
        chk({nm, ":done_stall"}, 32'(stall_mem), 32'd0);
        chk({nm, ":done_data"}, mem_data_mem1, (wr || tout) ? 32'd0 : ref_load(int'(f3), addr, rdw));
        chk({nm, ":done_fault"}, 32'(mem_fault), 32'(tout));
        chk({nm, ":done_is_tmo"}, 32'(fault_is_timeout), 32'(tout));
        chk({nm, ":done_regwrite"}, 32'(regwrite_mem_out1), 32'(regw & !tout));
        step();
        memread_mem  = 1'b0;
        memwrite_mem = 1'b0;
    endtask

    initial begin
        int pick;
        bit r, w;
        logic [2:0] f;
        rst = 1'b1;
        alu_result_mem = 32'h0; rs2_data_mem = 32'h0; rd_mem = 5'd0;
        regwrite_mem = 1'b1; memtoreg_mem_in = 1'b0;
        memread_mem = 1'b1; memwrite_mem = 1'b0; funct3_mem = 3'd2;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'h0;
        #3;
        chk("rst_req", 32'(dmem_if.dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_if.dmem_we), 32'd0);
        chk("rst_be", 32'(dmem_if.dmem_be), 32'd0);
        chk("rst_addr", dmem_if.dmem_addr, 32'd0);
        chk("rst_wdata", dmem_if.dmem_wdata, 32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_data", mem_data_mem1, 32'd0);
        step();
        memread_mem = 1'b0;
        rst = 1'b0;

        do_op("alu", 0, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 1, 5'd5);
        do_op("lb", 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 5'd7);
        do_op("lbu", 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 5'd7);
        do_op("sh", 0, 1, 3'd1, 32'h202, 32'hAAAA_BEEF, 32'h0, 2, 0, 5'd0);
        do_op("lw_mis", 1, 0, 3'd2, 32'h301, 32'h0, 32'h0, 0, 1, 5'd3);
        do_op("lw_tmo", 1, 0, 3'd2, 32'h400, 32'h0, 32'h1111_2222, 99, 1, 5'd4);
        do_op("lw_ack_last", 1, 0, 3'd2, 32'h400, 32'h0, 32'h3333_4444, TMO - 1, 1, 5'd4);
        do_op("lh_neg", 1, 0, 3'd1, 32'h502, 32'h0, 32'h8001_7FFF, 1, 1, 5'd9);
        do_op("sb_lane3", 0, 1, 3'd0, 32'h603, 32'h0000_00A5, 32'h0, 0, 0, 5'd0);
        do_op("ld_illegal", 1, 0, 3'd3, 32'h700, 32'h0, 32'h0, 0, 1, 5'd2);
        do_op("rdwr_illegal", 1, 1, 3'd2, 32'h700, 32'h0, 32'h0, 0, 1, 5'd2);

        // asynchronous reset while a request is outstanding
        memread_mem = 1'b1; memwrite_mem = 1'b0; funct3_mem = 3'd2;
        alu_result_mem = 32'h40; regwrite_mem = 1'b1;
        #4;
        chk("arst_c0_stall", 32'(stall_mem), 32'd1);
        step();
        chk("arst_req_before", 32'(dmem_if.dmem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_req", 32'(dmem_if.dmem_req), 32'd0);
        chk("arst_stall", 32'(stall_mem), 32'd0);
        chk("arst_data", mem_data_mem1, 32'd0);
        chk("arst_fault", 32'(mem_fault), 32'd0);
        memread_mem = 1'b0;
        #1 rst = 1'b0;
        step();
        chk("arst_idle_req", 32'(dmem_if.dmem_req), 32'd0);
        do_op("lw_after_rst", 1, 0, 3'd2, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1, 5'd1);

        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 9));
            r = 1'b0; w = 1'b0; f = 3'd0;
            case (pick)
                1: begin r = 1'b1; f = 3'd0; end
                2: begin r = 1'b1; f = 3'd1; end
                3: begin r = 1'b1; f = 3'd2; end
                4: begin r = 1'b1; f = 3'd4; end
                5: begin r = 1'b1; f = 3'd5; end
                6: begin w = 1'b1; f = 3'd0; end
                7: begin w = 1'b1; f = 3'd1; end
                8: begin w = 1'b1; f = 3'd2; end
                9: begin r = 1'b1; w = $urandom_range(0, 1) == 1; f = 3'($urandom_range(3, 7)); end
                default: ;
            endcase
            do_op("rnd", r, w, f, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, TMO)), $urandom_range(0, 1) == 1, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and MEM_WB. For RV32I loads and stores it performs the data-memory transaction over a single-outstanding req/ack bus, producing store byte-lanes and extended load data. It stalls the upstream pipeline until the access completes, and presents results to MEM_WB on the existing `*_mem1` / `memtoreg_mem` names.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles spent in REQ without `dmem_ack` before abort; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `alu_result_mem` in 32: effective address or ALU result from EX/MEM.
- `rs2_data_mem` in 32: store data.
- `rd_mem` in 5: destination register.
- `regwrite_mem` in 1: register write enable.
- `memtoreg_mem_in` in 1: write-back select.
- `memread_mem` in 1: load.
- `memwrite_mem` in 1: store.
- `funct3_mem` in 3: access size and sign.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: write, registered.
- `dmem_addr` out 32: word address {addr[31:2],2'b00}, registered.
- `dmem_wdata` out 32: lane-replicated store data, registered.
- `dmem_be` out 4: byte enables, registered; 0 for loads.
- `dmem_rdata` in 32: read word, valid with ack.
- `dmem_ack` in 1: transfer complete.
- `alu_result_mem1` out 32, `rd_mem_out1` out 5, `memtoreg_mem` out 1: combinational pass-through of the corresponding inputs.
- `regwrite_mem_out1` out 1: `regwrite_mem & ~stall_mem & ~mem_fault`.
- `mem_data_mem1` out 32: extended load data in DONE, else 0.
- `stall_mem` out 1: freeze PC/IF/ID/EX/MEM registers.
- `mem_fault` out 1: one-cycle fault pulse.
- `fault_is_timeout` out 1: qualifies `mem_fault`; 1 means timeout, 0 means misalignment or illegal access.

## Operation
- States are IDLE, REQ and DONE. Reset forces IDLE. During reset `dmem_req`/`dmem_we`/`dmem_be`/`dmem_addr`/`dmem_wdata`/rdata_q/counter are 0. `stall_mem`, `mem_fault` and `mem_data_mem1` are forced 0.
- An access is `memread_mem | memwrite_mem`.
- An access is illegal if both `memread_mem` and `memwrite_mem` are 1.
- An access is illegal for a load with funct3 ∈ {3,6,7}, or a store with funct3 > 2.
- An access is misaligned for a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- **IDLE, no access:** pass-through only, `stall_mem`=0.
- **IDLE, illegal or misaligned access:** no bus request, `stall_mem`=0, `mem_fault`=1 and `fault_is_timeout`=0 this cycle, regwrite gated off, stay in IDLE.
- **IDLE, legal access:** `stall_mem`=1. Register the bus outputs, set `dmem_req`=1, go to REQ.
- **REQ:** `stall_mem`=1. Hold all bus outputs stable until `dmem_ack`.
  - On ack, latch the formatted load data into rdata_q (0 for stores), drop `dmem_req`, go to DONE.
  - Without ack, increment the counter. Once TIMEOUT_CYCLES REQ cycles have elapsed without ack, drop `dmem_req`, set the timeout flag, go to DONE.
  - Ack in the expiry cycle wins over the timeout.
- **DONE:** `stall_mem`=0 and `mem_data_mem1`=rdata_q. If the timeout flag is set, `mem_fault`=1, `fault_is_timeout`=1 and regwrite is gated. Clear the flag and counter, return to IDLE.
- Stores:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: wdata=rs2, be=4'b1111.
- Loads select the byte or halfword lane by addr[1:0] from the registered address. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
- While stalled, regwrite is gated so MEM_WB captures bubbles. EX/MEM inputs are held stable by the stall.

## Timing
- Cycle 0: access presented, `stall_mem`=1.
- Cycle 1: `dmem_req`=1. The minimum case has `dmem_ack` in cycle 1.
- Cycle 2: DONE, `stall_mem`=0, MEM_WB captures at the end of cycle 2.
- Minimum load/store latency is 3 cycles, with 2 stall cycles. Each ack-wait cycle adds one.
- `dmem_ack` is ignored outside REQ.
- Asynchronous reset in REQ drops `dmem_req` immediately. No DONE cycle and no fault are produced.
- Non-memory instructions have zero added latency.

## Test plan
- ALU op, `regwrite_mem`=1, rd=5, result 0x1234 -> same cycle `alu_result_mem1`=0x1234, `rd_mem_out1`=5, `regwrite_mem_out1`=1, `stall_mem`=0.
- LB at addr 0x103, ack in cycle 1 with rdata 0x80FF_0000 -> `dmem_addr`=0x100, `mem_data_mem1`=0xFFFF_FF80 in cycle 2; stall high in cycles 0–1 only. The same access as LBU gives 0x0000_0080.
- SH at addr 0x202, rs2=0xAAAA_BEEF, ack delayed 3 cycles -> `dmem_be`=4'b1100, `dmem_wdata`=0xBEEF_BEEF, `dmem_we`=1 held stable; stall for 4 cycles.
- LW at addr 0x301 -> `mem_fault`=1 and `fault_is_timeout`=0 in cycle 0, no `dmem_req`, `regwrite_mem_out1`=0, `stall_mem`=0.
- TIMEOUT_CYCLES=4, load with no ack -> `dmem_req` low after 4 REQ cycles, then DONE with `mem_fault`=1, `fault_is_timeout`=1, `regwrite_mem_out1`=0. A repeat run with ack on the 4th REQ cycle completes with no fault.
- `rst` pulsed asynchronously mid-REQ -> `dmem_req`, `stall_mem` and `mem_data_mem1` go to 0 immediately, state is IDLE. A following LW at 0x0 completes normally.
